// File: rtl/caravel_wb_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : caravel_wb_bridge_pkg
//  Brief    : Shared soc types and constants for the Caravel Wishbone bridge.
//  Revision : 1.0  initial release
// ============================================================================
package caravel_wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } wb_state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/caravel_wb_bridge_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : wb_timeout_ctr
//  Brief    : Saturating cycle counter flagging when a request has run too long.
//  Revision : 1.0  initial release
// ============================================================================
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_width = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_width-1:0] c_last = c_width'(TIMEOUT_CYCLES - 1);
    localparam logic [c_width-1:0] c_max  = c_width'(TIMEOUT_CYCLES);

    logic [c_width-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_max)) begin
            r_count <= r_count + c_width'(1);
        end
    end

    // Fires in the cycle whose closing edge brings the count to TIMEOUT_CYCLES.
    assign expired = enable && (r_count >= c_last);

endmodule
`default_nettype wire

// File: rtl/caravel_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : caravel_wb_bridge
//  Brief    : Wishbone classic slave decoding one window onto a valid/ready
//             request port with a response timeout.
//  Revision : 1.0  initial release
// ============================================================================
module caravel_wb_bridge
    import caravel_wb_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          WINDOW_BITS    = 20,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic                   req_we_o,
    output logic [WINDOW_BITS-1:0] req_addr_o,
    output logic [31:0]            req_wdata_o,
    output logic [3:0]             req_be_o,
    input  logic                   rsp_valid_i,
    input  logic [31:0]            rsp_rdata_i,
    output logic                   timeout_o
);

    wb_state_t   r_state;
    wb_state_t   w_state_nxt;
    logic        w_stb;
    logic        w_hit;
    logic        w_expired;
    logic        w_clear;
    logic        w_load;
    logic        w_valid_nxt;
    logic        w_ack_nxt;
    logic [31:0] w_dat_nxt;
    logic        w_timeout_nxt;

    assign w_stb = wbs_cyc_i & wbs_stb_i;
    assign w_hit = (wbs_adr_i >> WINDOW_BITS) == (BASE_ADDR >> WINDOW_BITS);

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (w_clear),
        .enable ((r_state == ST_REQ) || (r_state == ST_WAIT)),
        .expired(w_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ack and data are decided on entry to ACK so they appear as registered
    // outputs during the single ACK cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_clear       = 1'b0;
        w_load        = 1'b0;
        w_valid_nxt   = 1'b0;
        w_ack_nxt     = 1'b0;
        w_dat_nxt     = '0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_stb && w_hit) begin
                    w_state_nxt = ST_REQ;
                    w_clear     = 1'b1;
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                end else if (w_stb) begin
                    w_state_nxt = ST_ACK;
                    w_ack_nxt   = 1'b1;
                    w_dat_nxt   = ERR_DATA;
                end
            end
            ST_REQ: begin
                if (req_ready_i) begin
                    w_state_nxt = ST_WAIT;
                end else if (w_expired) begin
                    w_state_nxt   = ST_ACK;
                    w_timeout_nxt = 1'b1;
                    w_ack_nxt     = w_stb;
                    w_dat_nxt     = w_stb ? ERR_DATA : 32'h0;
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (rsp_valid_i) begin
                    w_state_nxt = ST_ACK;
                    w_ack_nxt   = w_stb;
                    w_dat_nxt   = (w_stb && !req_we_o) ? rsp_rdata_i : 32'h0;
                end else if (w_expired) begin
                    w_state_nxt   = ST_ACK;
                    w_timeout_nxt = 1'b1;
                    w_ack_nxt     = w_stb;
                    w_dat_nxt     = w_stb ? ERR_DATA : 32'h0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            req_valid_o <= 1'b0;
            timeout_o   <= 1'b0;
            req_we_o    <= 1'b0;
            req_addr_o  <= '0;
            req_wdata_o <= '0;
            req_be_o    <= '0;
        end else begin
            wbs_ack_o   <= w_ack_nxt;
            wbs_dat_o   <= w_dat_nxt;
            req_valid_o <= w_valid_nxt;
            timeout_o   <= w_timeout_nxt;
            if (w_load) begin
                req_we_o    <= wbs_we_i;
                req_addr_o  <= wbs_adr_i[WINDOW_BITS-1:0];
                req_wdata_o <= wbs_we_i ? wbs_dat_i : 32'h0;
                req_be_o    <= wbs_sel_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_caravel_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_caravel_wb_bridge
//  Brief    : Self-checking bench for caravel_wb_bridge against a transaction
//             level expectation model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_caravel_wb_bridge;

    localparam int          c_to   = 8;
    localparam int          c_win  = 25;
    localparam int          c_never = 99;
    localparam logic [31:0] c_err  = 32'hDEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        req_valid_o, req_ready_i, req_we_o;
    logic [19:0] req_addr_o;
    logic [31:0] req_wdata_o;
    logic [3:0]  req_be_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_rdata_i;
    logic        timeout_o;

    int total = 0;
    int bad   = 0;

    int          obs_vcnt, obs_acks, obs_ack_k, obs_tos, obs_to_k, obs_fld_bad, obs_dat_bad;
    logic [31:0] obs_ack_dat;

    always #5 clk_i = ~clk_i;

    caravel_wb_bridge #(
        .BASE_ADDR     (32'h3000_0000),
        .WINDOW_BITS   (20),
        .TIMEOUT_CYCLES(c_to)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i),
        .req_we_o   (req_we_o),
        .req_addr_o (req_addr_o),
        .req_wdata_o(req_wdata_o),
        .req_be_o   (req_be_o),
        .rsp_valid_i(rsp_valid_i),
        .rsp_rdata_i(rsp_rdata_i),
        .timeout_o  (timeout_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drives one Wishbone transfer (called right after a negedge) and plays the
    // request-side responder; observations are collected over a fixed window.
    task automatic run_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input int rdy_dly, input int rsp_dly,
                           input logic [31:0] rdata, input logic abort, input int stray_k);
        int   req_idx = 0;
        int   wait_idx = 0;
        logic in_wait = 1'b0;
        logic hs_pend = 1'b0;
        obs_vcnt = 0; obs_acks = 0; obs_ack_k = 0; obs_tos = 0; obs_to_k = 0;
        obs_fld_bad = 0; obs_dat_bad = 0; obs_ack_dat = '0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0;
        for (int k = 1; k <= c_win; k++) begin
            @(negedge clk_i);
            rsp_valid_i = 1'b0;
            if (hs_pend) begin
                in_wait = 1'b1; wait_idx = 0; hs_pend = 1'b0;
            end else if (in_wait) begin
                wait_idx++;
            end
            if (req_valid_o) begin
                obs_vcnt++;
                if (req_addr_o !== adr[19:0] || req_be_o !== sel || req_we_o !== we ||
                    req_wdata_o !== (we ? dat : 32'h0))
                    obs_fld_bad++;
            end
            if (wbs_ack_o) begin
                obs_acks++;
                if (obs_acks == 1) begin
                    obs_ack_k = k; obs_ack_dat = wbs_dat_o;
                end
            end else if (wbs_dat_o != 32'h0) begin
                obs_dat_bad++;
            end
            if (timeout_o) begin
                obs_tos++;
                if (obs_tos == 1) obs_to_k = k;
            end
            if (wbs_ack_o || (abort && in_wait && wait_idx == 0)) begin
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
            req_ready_i = req_valid_o && (req_idx >= rdy_dly);
            if (req_valid_o) begin
                if (req_ready_i) hs_pend = 1'b1;
                req_idx++;
            end
            if (in_wait && wait_idx == rsp_dly) begin
                rsp_valid_i = 1'b1; rsp_rdata_i = rdata;
            end
            if (k == stray_k) begin
                rsp_valid_i = 1'b1; rsp_rdata_i = 32'h5555_AAAA;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0;
    endtask

    // Expected outcome from the transfer's attributes alone: window decode,
    // handshake delay, response delay, timeout budget and master abort.
    task automatic check_txn(input string tag, input logic [31:0] adr, input logic we,
                             input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                             input logic abort);
        logic        hit;
        int          e_vcnt, e_acks, e_ack_k, e_tos, e_to_k;
        logic [31:0] e_dat;
        hit = (adr[31:20] == 12'h300);
        if (!hit) begin
            e_vcnt = 0; e_acks = 1; e_ack_k = 1; e_dat = c_err; e_tos = 0; e_to_k = 0;
        end else if (rdy_dly >= c_to) begin
            e_vcnt = c_to; e_acks = 1; e_ack_k = c_to + 1; e_dat = c_err;
            e_tos = 1; e_to_k = c_to + 1;
        end else begin
            e_vcnt = rdy_dly + 1; e_acks = abort ? 0 : 1;
            e_ack_k = abort ? 0 : rdy_dly + rsp_dly + 3;
            e_dat = abort ? 32'h0 : (we ? 32'h0 : rdata);
            e_tos = 0; e_to_k = 0;
        end
        chk({tag, ".vcnt"}, 64'(obs_vcnt), 64'(e_vcnt));
        chk({tag, ".acks"}, 64'(obs_acks), 64'(e_acks));
        chk({tag, ".ack_cycle"}, 64'(obs_ack_k), 64'(e_ack_k));
        chk({tag, ".ack_data"}, 64'(obs_ack_dat), 64'(e_dat));
        chk({tag, ".timeouts"}, 64'(obs_tos), 64'(e_tos));
        chk({tag, ".timeout_cycle"}, 64'(obs_to_k), 64'(e_to_k));
        chk({tag, ".req_fields"}, 64'(obs_fld_bad), 64'd0);
        chk({tag, ".dat_idle_zero"}, 64'(obs_dat_bad), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] adr, dat, rdata;
        logic        we, abort;
        logic [3:0]  sel;
        int          rdy, rsp, hits;

        rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_rdata_i = '0;
        repeat (3) @(negedge clk_i);
        chk("reset.ctl", 64'({wbs_ack_o, req_valid_o, timeout_o, req_we_o, req_be_o}), 64'd0);
        chk("reset.dat", 64'(wbs_dat_o), 64'd0);
        chk("reset.req", 64'({req_addr_o, req_wdata_o}), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, 0, 0, 32'h1234_5678, 1'b0, 0);
        check_txn("read_hit", 32'h3000_0010, 1'b0, 0, 0, 32'h1234_5678, 1'b0);

        run_txn(32'h3000_0404, 1'b1, 4'b0101, 32'hA5A5_5A5A, 5, 1, 32'hFFFF_FFFF, 1'b0, 0);
        check_txn("write_hit", 32'h3000_0404, 1'b1, 5, 1, 32'hFFFF_FFFF, 1'b0);

        run_txn(32'h2000_0000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0, 0);
        check_txn("miss", 32'h2000_0000, 1'b0, 0, 0, 32'h0, 1'b0);

        run_txn(32'h3000_0020, 1'b0, 4'hF, 32'h0, c_never, c_never, 32'h0, 1'b0, 12);
        check_txn("timeout", 32'h3000_0020, 1'b0, c_never, c_never, 32'h0, 1'b0);

        run_txn(32'h3000_0030, 1'b0, 4'hF, 32'h0, 1, 2, 32'hCAFE_F00D, 1'b1, 0);
        check_txn("abort", 32'h3000_0030, 1'b0, 1, 2, 32'hCAFE_F00D, 1'b1);

        // Handshake on the last budgeted cycle must not raise timeout there.
        run_txn(32'h3000_0040, 1'b0, 4'hF, 32'h0, c_to - 1, c_never, 32'h0, 1'b0, 0);
        chk("prio.vcnt", 64'(obs_vcnt), 64'(c_to));
        chk("prio.no_timeout_at_hs", 64'(obs_to_k == c_to + 1), 64'd0);
        chk("prio.acks", 64'(obs_acks), 64'd1);

        // Reset while a write request is outstanding.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hC;
        wbs_adr_i = 32'h3000_0ABC; wbs_dat_i = 32'h1357_9BDF; req_ready_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid.valid_before", 64'(req_valid_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mid.ctl", 64'({wbs_ack_o, req_valid_o, timeout_o, req_we_o, req_be_o}), 64'd0);
        chk("rst_mid.dat", 64'(wbs_dat_o), 64'd0);
        chk("rst_mid.req", 64'({req_addr_o, req_wdata_o}), 64'd0);
        rst_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        hits = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            if (wbs_ack_o || timeout_o || req_valid_o) hits++;
        end
        chk("rst_mid.quiet", 64'(hits), 64'd0);
        run_txn(32'h3000_0100, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0BAD_CAFE, 1'b0, 0);
        check_txn("after_rst", 32'h3000_0100, 1'b0, 0, 0, 32'h0BAD_CAFE, 1'b0);

        // Back-to-back reads: next strobe presented as soon as the ack is seen.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0200; req_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rsp_valid_i = 1'b1; rsp_rdata_i = 32'h1111_2222;
        @(negedge clk_i);
        rsp_valid_i = 1'b0;
        chk("b2b.ack1", 64'({wbs_ack_o, wbs_dat_o}), {32'd1, 32'h1111_2222});
        wbs_adr_i = 32'h3000_0300;
        @(negedge clk_i);
        chk("b2b.gap", 64'({wbs_ack_o, req_valid_o}), 64'd0);
        @(negedge clk_i);
        chk("b2b.req2", 64'({req_valid_o, req_addr_o}), 64'({1'b1, 20'h00300}));
        @(negedge clk_i);
        rsp_valid_i = 1'b1; rsp_rdata_i = 32'h3333_4444;
        @(negedge clk_i);
        rsp_valid_i = 1'b0;
        chk("b2b.ack2", 64'({wbs_ack_o, wbs_dat_o}), {32'd1, 32'h3333_4444});
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; req_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < 40; i++) begin
            adr = $urandom;
            if ($urandom_range(0, 9) < 7) adr[31:20] = 12'h300;
            else if (adr[31:20] == 12'h300) adr[31] = 1'b1;
            we    = 1'($urandom_range(0, 1));
            sel   = 4'($urandom);
            dat   = $urandom;
            rdata = $urandom;
            rdy   = ($urandom_range(0, 19) == 0) ? c_never : $urandom_range(0, 3);
            rsp   = $urandom_range(0, 2);
            abort = ($urandom_range(0, 9) == 0) && (rdy < c_to);
            run_txn(adr, we, sel, dat, rdy, rsp, rdata, abort, 0);
            check_txn($sformatf("rnd%0d", i), adr, we, rdy, rsp, rdata, abort);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/caravel_wb_bridge.md
CARAVEL_WB_BRIDGE -- requirements
Module: caravel_wb_bridge

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h3000_0000, the base of the decoded Wishbone window.
REQ-002 The block SHALL have parameter WINDOW_BITS, default 20, the log2 size of the window in bytes.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum cycles spent in REQ plus WAIT.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have these ports:
- clk_i  input  1  sole clock.
- rst_i  input  1  synchronous active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic cycle, strobe and write.
- wbs_sel_i  input  4  byte selects.
- wbs_adr_i, wbs_dat_i  input  32 each  address and write data.
- wbs_ack_o  output  1  transfer acknowledge.
- wbs_dat_o  output  32  read data.
- req_valid_o  output  1  internal request valid.
- req_ready_i  input  1  internal request accepted.
- req_we_o  output  1  write request.
- req_addr_o  output  WINDOW_BITS  byte offset into the window.
- req_wdata_o  output  32  write data.
- req_be_o  output  4  byte enables.
- rsp_valid_i  input  1  response valid, one-cycle pulse.
- rsp_rdata_i  input  32  response data.
- timeout_o  output  1  one-cycle pulse on timeout.

Function
REQ-006 The FSM SHALL have states IDLE, REQ, WAIT, ACK.
REQ-007 In IDLE, when wbs_cyc_i & wbs_stb_i are high, the block SHALL register we, sel, dat and adr.
REQ-008 On a hit (wbs_adr_i[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]) the FSM SHALL go to REQ; on a miss it SHALL go to ACK with data 32'hDEAD_BEEF and issue no request.
REQ-009 In REQ, req_valid_o SHALL be high, and all req_* fields SHALL hold stable until the cycle in which req_valid_o & req_ready_i are both high; the FSM SHALL then go to WAIT.
REQ-010 req_addr_o SHALL equal adr[WINDOW_BITS-1:0] and req_be_o SHALL equal sel.
- On writes, req_wdata_o SHALL equal dat.
- On reads, req_wdata_o SHALL be 0.
REQ-011 In WAIT, rsp_valid_i SHALL move the FSM to ACK, with return data rsp_rdata_i on reads and 0 on writes.
- rsp_valid_i SHALL be ignored in IDLE, REQ and ACK, including late responses after a timeout.
REQ-012 A counter of width $clog2(TIMEOUT_CYCLES+1) SHALL clear on entry to REQ and increment every cycle in REQ and WAIT.
- When it equals TIMEOUT_CYCLES, the FSM SHALL go to ACK with data 32'hDEAD_BEEF.
- timeout_o SHALL pulse high for one cycle.
- req_valid_o SHALL drop in that same cycle.
REQ-013 In ACK, wbs_ack_o SHALL be high for exactly one cycle if wbs_cyc_i & wbs_stb_i are still high; otherwise the FSM SHALL return to IDLE without an ack (master abort).
- After ACK the FSM SHALL always return to IDLE.
REQ-014 wbs_dat_o SHALL carry return data only while wbs_ack_o is high, and SHALL be 0 otherwise.
REQ-015 Latency, from the edge that samples the strobe:
- A hit with immediate ready and a response in the first WAIT cycle SHALL ack 3 cycles later.
- A miss SHALL ack 1 cycle later.
- The minimum back-to-back hit period SHALL be 4 cycles.
REQ-016 wbs_ack_o and req_valid_o SHALL be registered outputs.
REQ-017 A handshake in the same cycle the timeout fires SHALL take priority: the FSM goes to WAIT and timeout_o stays low.

Reset
REQ-018 While rst_i is high at a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear.
- wbs_ack_o, wbs_dat_o, req_valid_o, req_we_o, req_addr_o, req_wdata_o, req_be_o and timeout_o SHALL all be 0.
REQ-019 A reset mid-transaction SHALL abandon the transaction, with no ack and no timeout pulse.

Structure
REQ-020 The FSM state typedef and constant ERR_DATA = 32'hDEAD_BEEF SHALL live in the shared soc package.
REQ-021 The timeout counter SHALL be a sub-module named wb_timeout_ctr, with inputs clear and enable and output expired.

Verification
REQ-022 Read hit:
- Stimulus: adr 32'h3000_0010, ready held high, rsp one cycle after handshake with 32'h1234_5678.
- Required: req_addr_o 0x00010, ack 3 cycles after strobe, wbs_dat_o 32'h1234_5678.
REQ-023 Write hit:
- Stimulus: sel 4'b0101, dat 32'hA5A5_5A5A, ready delayed 5 cycles.
- Required: req fields stable for all 5 cycles, req_be_o 4'b0101, ack with wbs_dat_o 0.
REQ-024 Miss:
- Stimulus: adr 32'h2000_0000.
- Required: no req_valid_o, ack 1 cycle later with 32'hDEAD_BEEF.
REQ-025 Timeout:
- Stimulus: TIMEOUT_CYCLES=8, ready never asserted.
- Required: req_valid_o high for 8 cycles, then timeout_o pulse and ack with 32'hDEAD_BEEF.
- Follow-up stimulus: a stray rsp_valid_i later.
- Required: ignored.
REQ-026 Abort and reset:
- Stimulus: wbs_cyc_i dropped during WAIT.
- Required: no ack.
- Stimulus: rst_i asserted during REQ.
- Required: all outputs 0 next cycle, and the next transaction completes normally.
